mem_bist_ctrl: RTL and testbench

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

---
 rtl/mem_bist_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_ctrl.sv
// March C- memory BIST controller: drives a word-wide RAM window through six
// March elements, checks every read one cycle later and latches the first failure.
module mem_bist_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_test,
    output logic                  test_o,
    output logic                  go_nogo,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [1:0] ST_ARMED = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] EL_M0 = 3'd0;
    localparam logic [2:0] EL_M5 = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    // Element properties of March C-: M3/M4 walk downwards, M1..M4 are read-then-write.
    function automatic logic el_is_down(input logic [2:0] el);
        case (el)
            3'd3, 3'd4: el_is_down = 1'b1;
            default:    el_is_down = 1'b0;
        endcase
    endfunction

    function automatic logic el_is_pair(input logic [2:0] el);
        case (el)
            3'd1, 3'd2, 3'd3, 3'd4: el_is_pair = 1'b1;
            default:                el_is_pair = 1'b0;
        endcase
    endfunction

    function automatic logic el_read_bg(input logic [2:0] el);
        case (el)
            3'd2, 3'd4: el_read_bg = 1'b1;
            default:    el_read_bg = 1'b0;
        endcase
    endfunction

    function automatic logic el_write_bg(input logic [2:0] el);
        case (el)
            3'd1, 3'd3: el_write_bg = 1'b1;
            default:    el_write_bg = 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] bg_word(input logic b);
        bg_word = {DATA_WIDTH{b}};
    endfunction

    logic [1:0]            state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  phase_q, phase_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  cmp_vld_q, cmp_vld_d;
    logic [DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d;
    logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]            cmp_elem_q, cmp_elem_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]            fail_elem_q, fail_elem_d;
    logic                  test_q, test_d;

    logic                  last_addr_s;
    logic                  mismatch_s;
    logic [2:0]            elem_nxt_s;

    // Next-op sequencing, read-compare pipeline and first-failure capture.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        phase_d     = phase_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cmp_vld_d   = 1'b0;
        cmp_exp_d   = cmp_exp_q;
        cmp_addr_d  = cmp_addr_q;
        cmp_elem_d  = cmp_elem_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        test_d      = test_q;

        elem_nxt_s  = elem_q + 3'd1;
        if (el_is_down(elem_q)) begin
            last_addr_s = (mem_addr_q == ADDR_ZERO);
        end else begin
            last_addr_s = (mem_addr_q == ADDR_MAX);
        end

        // Only the first mismatch is recorded; later ones leave the registers alone.
        mismatch_s = cmp_vld_q && (mem_rdata_i != cmp_exp_q);
        if (mismatch_s && pass_q) begin
            pass_d      = 1'b0;
            fail_addr_d = cmp_addr_q;
            fail_elem_d = cmp_elem_q;
        end else begin
            pass_d      = pass_q;
        end

        case (state_q)
            ST_ARMED: begin
                mem_req_d = 1'b0;
                if (!start_test) begin
                    state_d     = ST_RUN;
                    elem_d      = EL_M0;
                    phase_d     = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_ZERO;
                    mem_wdata_d = DATA_ZERO;
                    pass_d      = 1'b1;
                    fail_addr_d = ADDR_ZERO;
                    fail_elem_d = 3'd0;
                end else begin
                    state_d     = ST_ARMED;
                end
            end
            ST_RUN: begin
                cmp_vld_d  = ~mem_we_q;
                cmp_exp_d  = bg_word(el_read_bg(elem_q));
                cmp_addr_d = mem_addr_q;
                cmp_elem_d = elem_q;
                if (el_is_pair(elem_q) && !phase_q) begin
                    phase_d     = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = bg_word(el_write_bg(elem_q));
                end else if (!last_addr_s) begin
                    phase_d     = 1'b0;
                    mem_we_d    = (elem_q == EL_M0);
                    mem_wdata_d = DATA_ZERO;
                    if (el_is_down(elem_q)) begin
                        mem_addr_d = mem_addr_q - ADDR_ONE;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_ONE;
                    end
                end else if (elem_q != EL_M5) begin
                    // Every element after M0 opens with a read.
                    elem_d      = elem_nxt_s;
                    phase_d     = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = DATA_ZERO;
                    mem_addr_d  = el_is_down(elem_nxt_s) ? ADDR_MAX : ADDR_ZERO;
                end else begin
                    state_d     = ST_DRAIN;
                    elem_d      = EL_M0;
                    phase_d     = 1'b0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = ADDR_ZERO;
                    mem_wdata_d = DATA_ZERO;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                test_d  = 1'b0;
            end
            ST_DONE: begin
                if (start_test) begin
                    state_d     = ST_ARMED;
                    test_d      = 1'b1;
                    pass_d      = 1'b1;
                    fail_addr_d = ADDR_ZERO;
                    fail_elem_d = 3'd0;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_ARMED;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = ADDR_ZERO;
                mem_wdata_d = DATA_ZERO;
                test_d      = 1'b1;
            end
        endcase
    end

    // State and output registers; reset parks the controller in ARMED at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_ARMED;
            elem_q      <= 3'd0;
            phase_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ADDR_ZERO;
            mem_wdata_q <= DATA_ZERO;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= DATA_ZERO;
            cmp_addr_q  <= ADDR_ZERO;
            cmp_elem_q  <= 3'd0;
            pass_q      <= 1'b0;
            fail_addr_q <= ADDR_ZERO;
            fail_elem_q <= 3'd0;
            test_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            phase_q     <= phase_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            test_q      <= test_d;
        end
    end

    assign test_o      = test_q;
    assign go_nogo     = pass_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: behavioural RAM with an optional stuck-at bit,
// a table of fault scenarios plus hand-written reset/idle/trace sequences.
module tb_mem_bist_ctrl;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int N   = 16;
    localparam int OPS = 160;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_test;
    logic          test_o, go_nogo;
    logic [AW-1:0] fail_addr_o;
    logic [2:0]    fail_elem_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] rdata_q = '0;

    mem_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_test(start_test),
        .test_o(test_o), .go_nogo(go_nogo),
        .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(rdata_q)
    );

    always #5 clk = ~clk;

    // RAM with one optional stuck-at cell bit; read data appears one cycle after the strobe.
    logic [DW-1:0] ram [0:N-1];
    logic          flt_en = 1'b0;
    int            flt_addr = 0;
    int            flt_bit = 0;
    logic          flt_val = 1'b0;

    function automatic logic [DW-1:0] fault_word(input logic [DW-1:0] d, input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = d;
        if (flt_en && int'(a) == flt_addr) r[flt_bit] = flt_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_req_o && mem_we_o)  ram[mem_addr_o] <= fault_word(mem_wdata_o, mem_addr_o);
        if (mem_req_o && !mem_we_o) rdata_q <= ram[mem_addr_o];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Trace of the last complete run.
    logic          tr_we    [0:OPS-1];
    logic [AW-1:0] tr_addr  [0:OPS-1];
    logic [DW-1:0] tr_wdata [0:OPS-1];

    // Arm for 'hold' cycles, start, then watch the whole run at negedges.
    task automatic run_test(input int hold, input logic armed_go);
        int reqs, rises, first_i, off_i, fall_i;
        logic prev;
        start_test = 1'b1;
        repeat (hold) @(negedge clk);
        check("armed_test_o", test_o, 1);
        check("armed_req", mem_req_o, 0);
        check("armed_go", go_nogo, armed_go);
        check("armed_fail_addr", fail_addr_o, 0);
        check("armed_fail_elem", fail_elem_o, 0);
        start_test = 1'b0;
        reqs = 0; rises = 0; first_i = -1; off_i = -1; fall_i = -1; prev = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            // A start_test glitch mid-run must be ignored.
            if (i == 30) start_test = 1'b1;
            if (i == 33) start_test = 1'b0;
            if (mem_req_o) begin
                if (reqs < OPS) begin
                    tr_we[reqs]    = mem_we_o;
                    tr_addr[reqs]  = mem_addr_o;
                    tr_wdata[reqs] = mem_wdata_o;
                end
                reqs++;
                if (!prev) rises++;
                if (first_i < 0) first_i = i;
            end else if (reqs > 0 && off_i < 0) begin
                off_i = i;
            end
            prev = mem_req_o;
            if (!test_o) begin
                fall_i = i;
                break;
            end
        end
        check("done_reached", fall_i > 0, 1);
        check("req_count", reqs, OPS);
        check("req_one_burst", rises, 1);
        check("first_req_cycle", first_i, 1);
        check("test_fall_lag", fall_i - off_i, 1);
    endtask

    typedef struct {
        logic en;
        int   addr;
        int   bitn;
        logic val;
        logic exp_go;
        int   exp_addr;
        int   exp_elem;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cnt, mism, k;
        logic [DW-1:0] sgo;

        vecs[0] = '{1'b0, 0,  0,  1'b0, 1'b1, 0,  0};
        vecs[1] = '{1'b1, 5,  3,  1'b0, 1'b0, 5,  2};
        vecs[2] = '{1'b1, 0,  0,  1'b1, 1'b0, 0,  1};
        vecs[3] = '{1'b1, 15, 31, 1'b0, 1'b0, 15, 2};
        vecs[4] = '{1'b1, 10, 16, 1'b1, 1'b0, 10, 1};
        vecs[5] = '{1'b0, 0,  0,  1'b0, 1'b1, 0,  0};

        for (int a = 0; a < N; a++) ram[a] = 32'hA5A5_5A5A;

        rst_ni = 1'b0;
        start_test = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_test_o", test_o, 1);
        check("rst_go", go_nogo, 0);
        check("rst_fail_addr", fail_addr_o, 0);
        check("rst_fail_elem", fail_elem_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        rst_ni = 1'b1;

        // start_test held high: the controller must stay armed and idle.
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_req_o || !test_o) cnt++;
        end
        check("idle_while_armed", cnt, 0);

        // Reset in the middle of RUN, then a clean restart.
        start_test = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 50; i++) begin
            @(negedge clk);
            if (mem_req_o) cnt++;
        end
        check("mid_run_reached", cnt, 50);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_req", mem_req_o, 0);
        check("mid_rst_test_o", test_o, 1);
        start_test = 1'b1;
        @(negedge clk);
        rst_ni = 1'b1;
        run_test(3, 1'b0);
        check("restart_go", go_nogo, 1);

        // Scenario table: consecutive reruns, each started from DONE.
        for (int v = 0; v < 6; v++) begin
            flt_en   = vecs[v].en;
            flt_addr = vecs[v].addr;
            flt_bit  = vecs[v].bitn;
            flt_val  = vecs[v].val;
            run_test(4, 1'b1);
            check($sformatf("v%0d_go", v), go_nogo, vecs[v].exp_go);
            check($sformatf("v%0d_fail_addr", v), fail_addr_o, vecs[v].exp_addr);
            check($sformatf("v%0d_fail_elem", v), fail_elem_o, vecs[v].exp_elem);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_done_hold", v),
                  {test_o, mem_req_o, go_nogo, fail_addr_o, fail_elem_o},
                  {1'b0, 1'b0, vecs[v].exp_go, 4'(vecs[v].exp_addr), 3'(vecs[v].exp_elem)});

            if (v == 0) begin
                // March C- reference sequence built from the element list.
                mism = 0;
                k = 0;
                for (int a = 0; a < N; a++) begin
                    if (tr_we[k] !== 1'b1 || tr_addr[k] !== AW'(a) || tr_wdata[k] !== '0) mism++;
                    k++;
                end
                for (int el = 1; el <= 4; el++) begin
                    sgo = (el == 1 || el == 3) ? '1 : '0;
                    for (int j = 0; j < N; j++) begin
                        int a;
                        a = (el >= 3) ? (N - 1 - j) : j;
                        if (tr_we[k] !== 1'b0 || tr_addr[k] !== AW'(a)) mism++;
                        k++;
                        if (tr_we[k] !== 1'b1 || tr_addr[k] !== AW'(a) || tr_wdata[k] !== sgo) mism++;
                        k++;
                    end
                end
                for (int a = 0; a < N; a++) begin
                    if (tr_we[k] !== 1'b0 || tr_addr[k] !== AW'(a)) mism++;
                    k++;
                end
                check("trace_ops", mism, 0);
                check("m0_first_write", {tr_we[0], tr_addr[0]}, {1'b1, 4'd0});
                check("m3_first_read", {tr_we[80], tr_addr[80]}, {1'b0, 4'd15});
                check("m5_last_read", {tr_we[159], tr_addr[159]}, {1'b0, 4'd15});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
